sbm_mult_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one digit-serial multiplier (sbm_digitized-style

---
 rtl/sbm_mult_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sbm_mult_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbm_mult_arbiter.sv
// Round-robin arbiter sharing one start/done digit-serial multiplier among NREQ requesters.
// Optional RUN-state watchdog enabled by defining SBM_ARB_TIMEOUT_EN.
module sbm_mult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned SIZEA   = 1024,
  parameter int unsigned SIZEB   = 1024,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*SIZEA-1:0]  req_a_i,
  input  logic [NREQ*SIZEB-1:0]  req_b_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [NREQ-1:0]        done_o,
  output logic [SIZEA+SIZEB-1:0] res_o,
  output logic [IDW-1:0]         res_id_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic [SIZEA-1:0]       mul_a_o,
  output logic [SIZEB-1:0]       mul_b_o,
  output logic                   mul_start_o,
  output logic                   mul_clr_o,
  input  logic [SIZEA+SIZEB-1:0] mul_c_i,
  input  logic                   mul_done_i
);

  localparam int unsigned SizeC = SIZEA + SIZEB;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapt, StClr} state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   pick;
  logic             pick_vld;
  logic             tmo;

  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [SizeC-1:0] res_q, res_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             busy_q, busy_d;
  logic [SIZEA-1:0] mul_a_q, mul_a_d;
  logic [SIZEB-1:0] mul_b_q, mul_b_d;
  logic             mul_start_q, mul_start_d;
  logic             mul_clr_q, mul_clr_d;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = IDW'(idx);
      end
    end
  end

`ifdef SBM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign tmo   = (state_q == StRun) && !mul_done_i && (cnt_q == CntW'(TIMEOUT - 1));
  assign cnt_d = (state_q == StRun) ? cnt_q + 1'b1 : '0;
  assign err_d = (state_q == StRun) && tmo;
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT;
  assign tmo            = 1'b0;
  assign err_o          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StLoad;
          win_d   = pick;
        end
      end
      StLoad: state_d = StRun;
      StRun:  if (mul_done_i || tmo) state_d = StCapt;
      StCapt: state_d = StClr;
      StClr: begin
        state_d = StIdle;
        ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; every output is registered from its next value.
  always_comb begin
    ack_d       = '0;
    done_d      = '0;
    res_d       = res_q;
    res_id_d    = res_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    busy_d      = (state_d != StIdle);
    mul_start_d = (state_d == StRun);
    mul_clr_d   = (state_d == StClr);
    if (state_q == StLoad) begin
      ack_d[win_q] = 1'b1;
      mul_a_d      = req_a_i[32'(win_q)*SIZEA +: SIZEA];
      mul_b_d      = req_b_i[32'(win_q)*SIZEB +: SIZEB];
    end
    if ((state_q == StRun) && (state_d == StCapt)) begin
      done_d[win_q] = 1'b1;
      res_id_d      = win_q;
      res_d         = tmo ? '0 : mul_c_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q       <= '0;
      done_q      <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      mul_clr_q   <= 1'b1;
    end else begin
      ack_q       <= ack_d;
      done_q      <= done_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      mul_clr_q   <= mul_clr_d;
    end
  end

  assign ack_o       = ack_q;
  assign done_o      = done_q;
  assign res_o       = res_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = busy_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_start_o = mul_start_q;
  assign mul_clr_o   = mul_clr_q;

endmodule

// File: tb/tb_sbm_mult_arbiter.sv
// Directed bench for sbm_mult_arbiter with a behavioural start/done multiplier core.
module tb_sbm_mult_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned SIZEA   = 1024;
  localparam int unsigned SIZEB   = 1024;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LAT     = 4;
  localparam int unsigned SC      = SIZEA + SIZEB;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*SIZEA-1:0] req_a = '0;
  logic [NREQ*SIZEB-1:0] req_b = '0;
  logic [NREQ-1:0]       ack, done;
  logic [SC-1:0]         res;
  logic [IDW-1:0]        res_id;
  logic                  err, busy;
  logic [SIZEA-1:0]      mul_a;
  logic [SIZEB-1:0]      mul_b;
  logic                  mul_start, mul_clr;
  logic [SC-1:0]         mul_c;
  logic                  mul_done;
  logic                  no_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbm_mult_arbiter #(
    .NREQ(NREQ), .SIZEA(SIZEA), .SIZEB(SIZEB), .IDW(IDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_a_i(req_a), .req_b_i(req_b),
    .ack_o(ack), .done_o(done), .res_o(res), .res_id_o(res_id), .err_o(err),
    .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_start_o(mul_start),
    .mul_clr_o(mul_clr), .mul_c_i(mul_c), .mul_done_i(mul_done)
  );

  // Core model: fixed LAT cycles of start, then level done until cleared.
  int core_cnt;
  always @(posedge clk) begin
    if (!rst_n || mul_clr) begin
      core_cnt <= 0;
      mul_done <= 1'b0;
      mul_c    <= '0;
    end else if (mul_start && !mul_done && !no_done) begin
      if (core_cnt == LAT - 1) begin
        mul_done <= 1'b1;
        mul_c    <= {{SIZEB{1'b0}}, mul_a} * {{SIZEA{1'b0}}, mul_b};
      end
      core_cnt <= core_cnt + 1;
    end
  end

  task automatic set_op(input int i, input logic [SIZEA-1:0] a, input logic [SIZEB-1:0] b);
    req_a[i*SIZEA +: SIZEA] = a;
    req_b[i*SIZEB +: SIZEB] = b;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    req     = '0;
    no_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == '0 && cyc < 200);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack, done, busy, err, mul_start, mul_clr} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctrl: got ack=%b done=%b busy=%b err=%b start=%b clr=%b, want 0 0 0 0 0 1",
               ack, done, busy, err, mul_start, mul_clr);
    end
    checks++;
    if (res !== '0 || res_id !== '0 || mul_a !== '0 || mul_b !== '0) begin
      errors++;
      $display("FAIL reset_data: got res_lo=%h res_id=%0d a_lo=%h b_lo=%h, want all 0",
               res[63:0], res_id, mul_a[63:0], mul_b[63:0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mul_clr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_release: got clr=%b busy=%b, want 0 0", mul_clr, busy);
    end
  endtask

  task automatic test_single();
    int cyc;
    set_op(0, 3, 5);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_c1: got ack=%b busy=%b, want 0000 1", ack, busy);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || mul_a !== 1024'd3 || mul_b !== 1024'd5 || mul_start !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: got ack=%b a=%0d b=%0d start=%b, want 0001 3 5 1",
               ack, mul_a[31:0], mul_b[31:0], mul_start);
    end
    req = '0;
    wait_done(cyc);
    checks++;
    if (done !== 4'b0001 || res !== 2048'd15 || res_id !== 2'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%b res=%0d id=%0d err=%b, want 0001 15 0 0",
               done, res[31:0], res_id, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0000 || mul_clr !== 1'b1 || res !== 2048'd15) begin
      errors++;
      $display("FAIL single_clr: got done=%b clr=%b res=%0d, want 0000 1 15",
               done, mul_clr, res[31:0]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mul_clr !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b clr=%b, want 0 0", busy, mul_clr);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0]  exp_done [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  exp_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_res  [5] = '{16'd20, 16'd33, 16'd48, 16'd65, 16'd20};
    apply_reset();
    set_op(0, 2, 10);
    set_op(1, 3, 11);
    set_op(2, 4, 12);
    set_op(3, 5, 13);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(cyc);
      checks++;
      if (done !== exp_done[k] || res_id !== exp_id[k] || res !== {2032'd0, exp_res[k]}) begin
        errors++;
        $display("FAIL rr_%0d: got done=%b id=%0d res=%0d, want %b %0d %0d",
                 k, done, res_id, res[31:0], exp_done[k], exp_id[k], exp_res[k]);
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_priority();
    int cyc;
    apply_reset();
    set_op(2, 6, 7);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    set_op(1, 9, 9);
    req = 4'b0010;
    wait_done(cyc);
    checks++;
    if (done !== 4'b0100 || res !== 2048'd42) begin
      errors++;
      $display("FAIL prio_first: got done=%b res=%0d, want 0100 42", done, res[31:0]);
    end
    set_op(2, 8, 8);
    req = 4'b0110;
    wait_done(cyc);
    checks++;
    if (done !== 4'b0010 || res_id !== 2'd1 || res !== 2048'd81) begin
      errors++;
      $display("FAIL prio_second: got done=%b id=%0d res=%0d, want 0010 1 81",
               done, res_id, res[31:0]);
    end
    req = 4'b0100;
    wait_done(cyc);
    checks++;
    if (done !== 4'b0100 || res_id !== 2'd2 || res !== 2048'd64) begin
      errors++;
      $display("FAIL prio_third: got done=%b id=%0d res=%0d, want 0100 2 64",
               done, res_id, res[31:0]);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_max_operands();
    int cyc;
    logic [SC-1:0] exp;
    exp = {{1023{1'b1}}, {1024{1'b0}}, 1'b1};
    set_op(3, {SIZEA{1'b1}}, {SIZEB{1'b1}});
    req = 4'b1000;
    wait_done(cyc);
    req = '0;
    checks++;
    if (done !== 4'b1000 || res_id !== 2'd3 || res !== exp) begin
      errors++;
      $display("FAIL max_res: got done=%b id=%0d hi=%h lo=%h, want 1000 3 hi=%h lo=%h",
               done, res_id, res[SC-1 -: 64], res[63:0], exp[SC-1 -: 64], exp[63:0]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    int stray;
    stray = 0;
    set_op(0, 2, 3);
    req = 4'b0001;
    cyc = 0;
    while (mul_start !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mul_clr !== 1'b1 || mul_start !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_abort: got busy=%b clr=%b start=%b done=%b, want 0 1 0 0000",
               busy, mul_clr, mul_start, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 4'b0000) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midrst_nodone: got %0d done pulses in reset, want 0", stray);
    end
    rst_n = 1'b1;
    wait_done(cyc);
    req = '0;
    checks++;
    if (done !== 4'b0001 || res !== 2048'd6) begin
      errors++;
      $display("FAIL midrst_after: got done=%b res=%0d, want 0001 6", done, res[31:0]);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef SBM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    int run_cyc;
    run_cyc = 0;
    apply_reset();
    no_done = 1'b1;
    set_op(1, 7, 7);
    req = 4'b0010;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mul_start === 1'b1) run_cyc++;
    end while (done == '0 && cyc < 100);
    req = '0;
    checks++;
    if (done !== 4'b0010 || err !== 1'b1 || res !== '0 || res_id !== 2'd1) begin
      errors++;
      $display("FAIL tmo_abort: got done=%b err=%b res=%0d id=%0d, want 0010 1 0 1",
               done, err, res[31:0], res_id);
    end
    checks++;
    if (run_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL tmo_cycles: got %0d RUN cycles, want %0d", run_cyc, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || mul_clr !== 1'b1) begin
      errors++;
      $display("FAIL tmo_pulse: got err=%b clr=%b, want 0 1", err, mul_clr);
    end
    no_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_max_operands();
    test_reset_mid_job();
`ifdef SBM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
